// File: rtl/lc4_mem_pkg.sv
// Shared constants for the LC4 instruction-fetch delay pipe.
// Defaults and mode encodings used by the top and its delay lines.
package lc4_mem_pkg;

  localparam int WORD_SIZE_DEF = 16;
  localparam int LATENCY_DEF   = 8;
  localparam int MAX_LATENCY   = 15;

  typedef enum logic {
    MODE_BYPASS = 1'b0,
    MODE_DELAY  = 1'b1
  } mode_e;

endpackage

// File: rtl/lc4_delay_line.sv
// One channel of the fetch delay: a DEPTH-stage {valid, data} shift
// register advancing on gwe, with flush, sync active-low reset and mode gating.
module lc4_delay_line
  import lc4_mem_pkg::*;
#(
  parameter int WIDTH = WORD_SIZE_DEF,
  parameter int DEPTH = LATENCY_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             gwe_i,
  input  logic             mode_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_value_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_value_o,
  output logic             busy_o
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];

  logic delay_mode;
  assign delay_mode = (mode_i == MODE_DELAY);

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (gwe_i) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        data_d[k] = data_q[k-1];
        vld_d[k]  = vld_q[k-1];
      end
      data_d[0] = in_value_i;
      vld_d[0]  = in_valid_i & delay_mode;
    end
    // Flush kills every entry, including the one sampled on this edge.
    if (flush_i) begin
      vld_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign out_valid_o = vld_q[DEPTH-1];
  assign out_value_o = data_q[DEPTH-1];
  assign busy_o      = delay_mode & (|vld_q);

endmodule

// File: rtl/lc4_insn_delay_pipe.sv
// Instruction-fetch latency emulator: N_PORTS delay lines between BRAM
// read ports and the core, with a combinational bypass when mode=0.
module lc4_insn_delay_pipe
  import lc4_mem_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int N_PORTS   = 2,
  parameter int LATENCY   = LATENCY_DEF
) (
  input  logic                           idclk,
  input  logic                           rst,
  input  logic                           gwe,
  input  logic                           mode,
  input  logic                           flush,
  input  logic [N_PORTS-1:0]             in_valid,
  input  logic [N_PORTS*WORD_SIZE-1:0]   in_value,
  output logic [N_PORTS-1:0]             out_valid,
  output logic [N_PORTS*WORD_SIZE-1:0]   out_value,
  output logic [N_PORTS-1:0]             busy
);

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_lat
    $error("lc4_insn_delay_pipe: LATENCY must be 1..15");
  end

  for (genvar p = 0; p < N_PORTS; p++) begin : g_ch
    logic                 dl_valid;
    logic [WORD_SIZE-1:0] dl_value;

    lc4_delay_line #(
      .WIDTH (WORD_SIZE),
      .DEPTH (LATENCY)
    ) u_dl (
      .clk_i       (idclk),
      .rst_ni      (rst),
      .gwe_i       (gwe),
      .mode_i      (mode),
      .flush_i     (flush),
      .in_valid_i  (in_valid[p]),
      .in_value_i  (in_value[p*WORD_SIZE +: WORD_SIZE]),
      .out_valid_o (dl_valid),
      .out_value_o (dl_value),
      .busy_o      (busy[p])
    );

    always_comb begin
      if (mode == MODE_DELAY) begin
        out_valid[p]                        = dl_valid;
        out_value[p*WORD_SIZE +: WORD_SIZE] = dl_value;
      end else begin
        out_valid[p]                        = in_valid[p];
        out_value[p*WORD_SIZE +: WORD_SIZE] = in_value[p*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

endmodule

// File: tb/tb_lc4_insn_delay_pipe.sv
// Directed bench: default instance (2 ch, latency 8) and a
// 3-channel, latency-3 instance for the mid-run reset scenario.
module tb_lc4_insn_delay_pipe;

  logic        clk;
  logic        rst, gwe, mode, flush;
  logic [1:0]  in_valid;
  logic [31:0] in_value;
  logic [1:0]  out_valid;
  logic [31:0] out_value;
  logic [1:0]  busy;

  logic        rst3, gwe3, mode3, flush3;
  logic [2:0]  in_valid3;
  logic [47:0] in_value3;
  logic [2:0]  out_valid3;
  logic [47:0] out_value3;
  logic [2:0]  busy3;

  int checks = 0;
  int errors = 0;

  lc4_insn_delay_pipe dut (
    .idclk     (clk),
    .rst       (rst),
    .gwe       (gwe),
    .mode      (mode),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_value  (in_value),
    .out_valid (out_valid),
    .out_value (out_value),
    .busy      (busy)
  );

  lc4_insn_delay_pipe #(
    .WORD_SIZE (16),
    .N_PORTS   (3),
    .LATENCY   (3)
  ) dut3 (
    .idclk     (clk),
    .rst       (rst3),
    .gwe       (gwe3),
    .mode      (mode3),
    .flush     (flush3),
    .in_valid  (in_valid3),
    .in_value  (in_value3),
    .out_valid (out_valid3),
    .out_value (out_value3),
    .busy      (busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; mode = 1'b1; gwe = 1'b0; flush = 1'b1;
    in_valid = 2'b11; in_value = 32'hFFFF_FFFF;
    tick();
    in_valid = 2'b00; in_value = '0; flush = 1'b0;
    tick();
    checks++;
    if (out_valid !== 2'b00) begin
      errors++;
      $display("FAIL reset_valid got %b exp 00", out_valid);
    end
    checks++;
    if (out_value !== 32'h0) begin
      errors++;
      $display("FAIL reset_value got %h exp 0", out_value);
    end
    checks++;
    if (busy !== 2'b00) begin
      errors++;
      $display("FAIL reset_busy got %b exp 00", busy);
    end
    rst = 1'b1;
  endtask

  task automatic test_latency();
    int pulses = 0;
    mode = 1'b1; gwe = 1'b1; flush = 1'b0;
    in_valid = 2'b01; in_value = 32'h0000_1234;
    tick();
    in_valid = 2'b00; in_value = '0;
    for (int j = 0; j <= 8; j++) begin
      logic ev;
      if (j > 0) tick();
      ev = (j == 7);
      if (out_valid[0]) pulses++;
      checks++;
      if (out_valid[0] !== ev) begin
        errors++;
        $display("FAIL lat_valid edge %0d got %b exp %b", j, out_valid[0], ev);
      end
      if (ev) begin
        checks++;
        if (out_value[15:0] !== 16'h1234) begin
          errors++;
          $display("FAIL lat_value got %h exp 1234", out_value[15:0]);
        end
      end
      checks++;
      if (busy[0] !== (j <= 7)) begin
        errors++;
        $display("FAIL lat_busy edge %0d got %b exp %b", j, busy[0], (j <= 7));
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL lat_pulses got %0d exp 1", pulses);
    end
  endtask

  task automatic test_stall();
    int pulses = 0;
    int edges = 0;
    mode = 1'b1; gwe = 1'b1; flush = 1'b0;
    in_valid = 2'b01; in_value = 32'h0000_5A5A;
    tick();
    in_valid = 2'b00; in_value = '0;
    for (int c = 1; c <= 12; c++) begin
      logic ev;
      gwe = (c < 4 || c > 6);
      tick();
      if (gwe) edges++;
      ev = (edges == 7) && gwe;
      if (out_valid[0]) pulses++;
      checks++;
      if (out_valid[0] !== ev) begin
        errors++;
        $display("FAIL stall_valid cyc %0d got %b exp %b", c, out_valid[0], ev);
      end
      if (ev) begin
        checks++;
        if (c != 10 || out_value[15:0] !== 16'h5A5A) begin
          errors++;
          $display("FAIL stall_value cyc %0d got %h exp 5a5a at cyc 10", c, out_value[15:0]);
        end
      end
    end
    gwe = 1'b1;
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL stall_pulses got %0d exp 1", pulses);
    end
  endtask

  task automatic test_flush();
    mode = 1'b1; gwe = 1'b1;
    checks++;
    if (busy !== 2'b00) begin
      errors++;
      $display("FAIL flush_pre_busy got %b exp 00", busy);
    end
    for (int i = 0; i < 16; i++) begin
      logic        ev;
      logic [15:0] xv;
      in_valid = {(i < 8), 1'b0};
      in_value = {16'hA000 + 16'(i), 16'h0};
      flush = (i == 4);
      tick();
      flush = 1'b0;
      if (i == 4) begin
        checks++;
        if (busy[1] !== 1'b0) begin
          errors++;
          $display("FAIL flush_busy got %b exp 0", busy[1]);
        end
      end
      ev = (i >= 12 && i <= 14);
      xv = 16'hA000 + 16'(i - 7);
      checks++;
      if (out_valid !== {ev, 1'b0}) begin
        errors++;
        $display("FAIL flush_valid edge %0d got %b exp %b0", i, out_valid, ev);
      end
      if (ev) begin
        checks++;
        if (out_value[31:16] !== xv) begin
          errors++;
          $display("FAIL flush_value edge %0d got %h exp %h", i, out_value[31:16], xv);
        end
      end
    end
    in_valid = 2'b00; in_value = '0;
  endtask

  task automatic test_bypass();
    mode = 1'b0; gwe = 1'b1; flush = 1'b0;
    in_valid = 2'b01; in_value = 32'h1111_BEEF;
    #1;
    checks++;
    if (out_valid !== 2'b01 || out_value !== 32'h1111_BEEF) begin
      errors++;
      $display("FAIL bypass_comb got %b/%h exp 01/1111beef", out_valid, out_value);
    end
    checks++;
    if (busy !== 2'b00) begin
      errors++;
      $display("FAIL bypass_busy got %b exp 00", busy);
    end
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (out_valid !== 2'b01 || out_value[15:0] !== 16'hBEEF) begin
      errors++;
      $display("FAIL bypass_hold got %b/%h", out_valid, out_value);
    end
    mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic ev;
      in_value = {16'h0, 16'hC000 + 16'(i)};
      in_valid = 2'b01;
      tick();
      ev = (i >= 7);
      checks++;
      if (out_valid[0] !== ev) begin
        errors++;
        $display("FAIL switch_valid edge %0d got %b exp %b", i, out_valid[0], ev);
      end
      if (ev) begin
        checks++;
        if (out_value[15:0] !== 16'hC000 + 16'(i - 7)) begin
          errors++;
          $display("FAIL switch_value edge %0d got %h exp %h", i, out_value[15:0],
                   16'hC000 + 16'(i - 7));
        end
      end
    end
    mode = 1'b0; in_valid = 2'b00; in_value = '0;
    #1;
    checks++;
    if (out_valid !== 2'b00 || busy !== 2'b00) begin
      errors++;
      $display("FAIL drop_valid got %b busy %b exp 00/00", out_valid, busy);
    end
    for (int i = 0; i < 9; i++) tick();
    mode = 1'b1;
    #1;
    checks++;
    if (busy !== 2'b00 || out_valid !== 2'b00) begin
      errors++;
      $display("FAIL drain_busy got %b valid %b exp 00/00", busy, out_valid);
    end
  endtask

  task automatic test_multi_reset();
    rst3 = 1'b1; mode3 = 1'b1; gwe3 = 1'b1; flush3 = 1'b0;
    in_valid3 = 3'b111; in_value3 = {16'h7777, 16'h6666, 16'h5555};
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (out_valid3 !== 3'b111 || busy3 !== 3'b111) begin
      errors++;
      $display("FAIL multi_pre got %b busy %b exp 111/111", out_valid3, busy3);
    end
    rst3 = 1'b0;
    tick();
    checks++;
    if (out_valid3 !== 3'b000 || out_value3 !== 48'h0 || busy3 !== 3'b000) begin
      errors++;
      $display("FAIL multi_rst got %b/%h/%b exp 0", out_valid3, out_value3, busy3);
    end
    rst3 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      for (int p = 0; p < 3; p++) begin
        in_valid3[p] = (i < 6) && !(p == 1 && (i % 2) == 1);
        in_value3[p*16 +: 16] = 16'((p + 1) << 12) | 16'(i);
      end
      tick();
      for (int p = 0; p < 3; p++) begin
        int   w;
        logic ev;
        w  = i - 2;
        ev = (w >= 0) && (w < 6) && !(p == 1 && (w % 2) == 1);
        checks++;
        if (out_valid3[p] !== ev) begin
          errors++;
          $display("FAIL multi_valid ch%0d edge %0d got %b exp %b", p, i, out_valid3[p], ev);
        end
        if (ev) begin
          checks++;
          if (out_value3[p*16 +: 16] !== (16'((p + 1) << 12) | 16'(w))) begin
            errors++;
            $display("FAIL multi_value ch%0d edge %0d got %h", p, i, out_value3[p*16 +: 16]);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; gwe = 1'b0; mode = 1'b1; flush = 1'b0;
    in_valid = '0; in_value = '0;
    rst3 = 1'b0; gwe3 = 1'b0; mode3 = 1'b1; flush3 = 1'b0;
    in_valid3 = '0; in_value3 = '0;
    test_reset();
    test_latency();
    test_stall();
    test_flush();
    test_bypass();
    test_multi_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
